swap_request_ctrl: RTL and testbench

Parametrised swap-request controller feeding the pixel buffer controller's `swap_buffer` input. It replaces ad-hoc key-driven swap FSMs with a debounced manual trigger, an optional free-running auto-swap mode, and a request/completion handshake with timeout. It sits in the `sys_clk` domain between board I/O (or the renderer) and the pixel buffer controller.

---
 rtl/swap_request_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_swap_request_ctrl.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swap_request_ctrl.sv
// swap_request_ctrl: debounced manual / periodic auto swap requests with a
// request/done handshake, timeout, pending coalescing and completion count.
//
// Ports:
//   sys_clk      in   single clock, rising edge
//   reset        in   synchronous active-high reset
//   key_n        in   raw active-low pushbutton (asynchronous)
//   enable       in   low blocks new requests and drops a pending one
//   mode_auto    in   high enables periodic auto requests
//   swap_done    in   one-cycle completion pulse from the buffer controller
//   swap_buffer  out  one-cycle swap request pulse
//   busy         out  high while a handshake is in progress
//   swap_count   out  completed swaps, wraps modulo 2^COUNT_W
//   timeout_err  out  sticky, handshake timed out
//   overrun      out  sticky, request arrived with one already pending
module swap_request_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int AUTO_PERIOD     = 833333,
    parameter int TIMEOUT_CYCLES  = 2000000,
    parameter int COUNT_W         = 16
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               key_n,
    input  logic               enable,
    input  logic               mode_auto,
    input  logic               swap_done,
    output logic               swap_buffer,
    output logic               busy,
    output logic [COUNT_W-1:0] swap_count,
    output logic               timeout_err,
    output logic               overrun
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int AP_W = $clog2(AUTO_PERIOD);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [AP_W-1:0] AP_MAX = AP_W'(AUTO_PERIOD - 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ASSERT_SWAP = 2'd1,
        WAIT_DONE   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic               sync1_q, key_sync_q;
    logic               key_db_q, key_db_d;
    logic               key_db_dly_q;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic [AP_W-1:0]    ap_cnt_q, ap_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               pending_q, pending_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               terr_q, terr_d;
    logic               ovr_q, ovr_d;

    logic manual_req;
    logic auto_tick;
    logic req;
    logic to_hit;

    // Two-flop synchroniser; idles released (high).
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            key_sync_q <= 1'b1;
        end else begin
            sync1_q    <= key_n;
            key_sync_q <= sync1_q;
        end
    end

    // Debounce: a level change is taken only after DEBOUNCE_CYCLES
    // consecutive cycles of disagreement.
    always_comb begin
        key_db_d = key_db_q;
        db_cnt_d = '0;
        if (key_sync_q != key_db_q) begin
            if (db_cnt_q == DB_MAX) begin
                key_db_d = key_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // Key release (rising key_db) is the manual trigger.
    assign manual_req = key_db_q & ~key_db_dly_q;

    // Period counter runs only while auto mode is live.
    always_comb begin
        ap_cnt_d = '0;
        if (mode_auto && enable && (ap_cnt_q != AP_MAX)) begin
            ap_cnt_d = ap_cnt_q + AP_W'(1);
        end
    end

    assign auto_tick = mode_auto & (ap_cnt_q == AP_MAX);

    // Simultaneous manual and auto triggers merge into one request.
    assign req    = enable & (manual_req | auto_tick);
    assign to_hit = (to_cnt_q == TO_MAX);

    // State register
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable && (req || pending_q)) begin
                    state_d = ASSERT_SWAP;
                end
            end
            ASSERT_SWAP: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (swap_done || to_hit) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        swap_buffer = (state_q == ASSERT_SWAP);
        busy        = (state_q != IDLE);
    end

    // Handshake datapath: pending flag, timer, count, sticky flags
    always_comb begin
        pending_d = pending_q;
        to_cnt_d  = '0;
        count_d   = count_q;
        terr_d    = terr_q;
        ovr_d     = ovr_q;
        if (state_q == IDLE) begin
            if (enable && (req || pending_q)) begin
                pending_d = 1'b0;
            end
        end else if (req) begin
            // Only one request is remembered; extras are flagged.
            if (pending_q) begin
                ovr_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end
        if (state_q == WAIT_DONE) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            if (swap_done) begin
                count_d = count_q + COUNT_W'(1);
            end else if (to_hit) begin
                terr_d = 1'b1;
            end
        end
        if (!enable) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            key_db_q     <= 1'b1;
            key_db_dly_q <= 1'b1;
            db_cnt_q     <= '0;
            ap_cnt_q     <= '0;
            to_cnt_q     <= '0;
            pending_q    <= 1'b0;
            count_q      <= '0;
            terr_q       <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            key_db_q     <= key_db_d;
            key_db_dly_q <= key_db_q;
            db_cnt_q     <= db_cnt_d;
            ap_cnt_q     <= ap_cnt_d;
            to_cnt_q     <= to_cnt_d;
            pending_q    <= pending_d;
            count_q      <= count_d;
            terr_q       <= terr_d;
            ovr_q        <= ovr_d;
        end
    end

    assign swap_count  = count_q;
    assign timeout_err = terr_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_swap_request_ctrl.sv
// Testbench for swap_request_ctrl: directed scenarios plus random stimulus
// compared every cycle against a behavioural model.
module tb_swap_request_ctrl;

    localparam int DB = 4;
    localparam int AP = 10;
    localparam int TO = 8;
    localparam int CW = 16;

    logic          sys_clk = 1'b0;
    logic          reset = 1'b1;
    logic          key_n = 1'b1;
    logic          enable = 1'b1;
    logic          mode_auto = 1'b0;
    logic          swap_done = 1'b0;
    logic          swap_buffer;
    logic          busy;
    logic [CW-1:0] swap_count;
    logic          timeout_err;
    logic          overrun;

    int n_chk = 0;
    int n_fail = 0;
    int ecount = 0;

    swap_request_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .AUTO_PERIOD    (AP),
        .TIMEOUT_CYCLES (TO),
        .COUNT_W        (CW)
    ) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .key_n      (key_n),
        .enable     (enable),
        .mode_auto  (mode_auto),
        .swap_done  (swap_done),
        .swap_buffer(swap_buffer),
        .busy       (busy),
        .swap_count (swap_count),
        .timeout_err(timeout_err),
        .overrun    (overrun)
    );

    always #5 sys_clk = ~sys_clk;

    // Behavioural model. m_age: -1 = no handshake, 0 = pulse cycle,
    // k>0 = k-th cycle spent waiting for completion.
    bit          m_s1 = 1, m_s2 = 1, m_db = 1, m_db_prev = 1;
    int          m_run = 0, m_aph = 0, m_age = -1, m_age_n;
    bit          m_pend = 0, m_pend_n, m_terr = 0, m_ovr = 0;
    bit          m_req;
    logic [CW-1:0] m_cnt = '0;

    always @(posedge sys_clk) begin
        ecount++;
        if (reset) begin
            m_s1 = 1; m_s2 = 1; m_db = 1; m_db_prev = 1;
            m_run = 0; m_aph = 0; m_age = -1; m_pend = 0;
            m_cnt = '0; m_terr = 0; m_ovr = 0;
        end else begin
            m_req = enable && ((m_db && !m_db_prev) ||
                               (mode_auto && m_aph == AP - 1));
            m_age_n = m_age;
            m_pend_n = m_pend;
            if (m_age < 0) begin
                if (enable && (m_req || m_pend)) begin
                    m_age_n = 0;
                    m_pend_n = 0;
                end
            end else begin
                if (m_req) begin
                    if (m_pend) m_ovr = 1;
                    else m_pend_n = 1;
                end
                if (m_age == 0) m_age_n = 1;
                else if (swap_done) begin
                    m_age_n = -1;
                    m_cnt = m_cnt + 1'b1;
                end else if (m_age == TO) begin
                    m_terr = 1;
                    m_age_n = -1;
                end else m_age_n = m_age + 1;
            end
            if (!enable) m_pend_n = 0;
            m_age = m_age_n;
            m_pend = m_pend_n;
            m_aph = (mode_auto && enable) ? (m_aph + 1) % AP : 0;
            m_db_prev = m_db;
            if (m_s2 != m_db) begin
                m_run++;
                if (m_run == DB) begin
                    m_db = m_s2;
                    m_run = 0;
                end
            end else m_run = 0;
            m_s2 = m_s1;
            m_s1 = key_n;
        end
    end

    function automatic logic [19:0] exp_vec();
        return {m_age == 0, m_age >= 0, m_terr, m_ovr, m_cnt};
    endfunction

    task automatic test_reset();
        reset = 1;
        repeat (2) @(negedge sys_clk);
        n_chk++;
        if ({swap_buffer, busy, timeout_err, overrun, swap_count} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_vals: got %h want 0",
                     {swap_buffer, busy, timeout_err, overrun, swap_count});
        end
        n_chk++;
        if (dut.key_db_q !== 1'b1 || dut.pending_q !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_int: key_db %b pending %b want 1 0",
                     dut.key_db_q, dut.pending_q);
        end
        reset = 0;
    endtask

    task automatic test_manual();
        int base, rel, np;
        mode_auto = 0;
        enable = 1;
        key_n = 0;
        repeat (10) begin
            @(negedge sys_clk);
            n_chk++;
            if ({swap_buffer, busy, timeout_err, overrun, swap_count} !== exp_vec()) begin
                n_fail++;
                $display("FAIL manual_press @%0d: got %h want %h", ecount,
                         {swap_buffer, busy, timeout_err, overrun, swap_count}, exp_vec());
            end
        end
        key_n = 1;
        base = ecount;
        np = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge sys_clk);
            rel = ecount - base;
            n_chk++;
            if ({swap_buffer, busy, timeout_err, overrun, swap_count} !== exp_vec()) begin
                n_fail++;
                $display("FAIL manual_model @%0d: got %h want %h", ecount,
                         {swap_buffer, busy, timeout_err, overrun, swap_count}, exp_vec());
            end
            n_chk++;
            if (swap_buffer !== (rel == 7)) begin
                n_fail++;
                $display("FAIL manual_pulse cycle %0d: got %b want %b",
                         rel, swap_buffer, rel == 7);
            end
            if (swap_buffer) np++;
            swap_done = (rel == 9);
        end
        n_chk++;
        if (swap_count !== 16'd1 || busy !== 1'b0 || np != 1) begin
            n_fail++;
            $display("FAIL manual_end: count %0d busy %b pulses %0d want 1 0 1",
                     swap_count, busy, np);
        end
    endtask

    task automatic test_bounce();
        int np = 0;
        for (int i = 0; i < 50; i++) begin
            key_n = (i >= 40) ? 1'b1 : (((i / 3) % 2) == 1);
            @(negedge sys_clk);
            n_chk++;
            if ({swap_buffer, busy, timeout_err, overrun, swap_count} !== exp_vec()) begin
                n_fail++;
                $display("FAIL bounce_model @%0d: got %h want %h", ecount,
                         {swap_buffer, busy, timeout_err, overrun, swap_count}, exp_vec());
            end
            n_chk++;
            if (dut.key_db_q !== 1'b1) begin
                n_fail++;
                $display("FAIL bounce_db @%0d: got %b want 1", ecount, dut.key_db_q);
            end
            if (swap_buffer) np++;
        end
        n_chk++;
        if (np != 0) begin
            n_fail++;
            $display("FAIL bounce_pulses: got %0d want 0", np);
        end
    endtask

    task automatic test_auto();
        int base, rel, np;
        reset = 1;
        @(negedge sys_clk);
        reset = 0;
        mode_auto = 1;
        swap_done = 0;
        base = ecount;
        np = 0;
        for (int i = 0; i < 55; i++) begin
            @(negedge sys_clk);
            rel = ecount - base;
            n_chk++;
            if ({swap_buffer, busy, timeout_err, overrun, swap_count} !== exp_vec()) begin
                n_fail++;
                $display("FAIL auto_model @%0d: got %h want %h", ecount,
                         {swap_buffer, busy, timeout_err, overrun, swap_count}, exp_vec());
            end
            n_chk++;
            if (swap_buffer !== (rel % 10 == 0)) begin
                n_fail++;
                $display("FAIL auto_pulse cycle %0d: got %b want %b",
                         rel, swap_buffer, rel % 10 == 0);
            end
            if (swap_buffer) np++;
            swap_done = (rel > 10) && (rel % 10 == 1);
        end
        swap_done = 0;
        n_chk++;
        if (swap_count !== 16'd5 || overrun !== 1'b0 || np != 5) begin
            n_fail++;
            $display("FAIL auto_end: count %0d ovr %b pulses %0d want 5 0 5",
                     swap_count, overrun, np);
        end
        mode_auto = 0;
    endtask

    task automatic test_timeout();
        int base, rel;
        reset = 1;
        @(negedge sys_clk);
        reset = 0;
        mode_auto = 1;
        swap_done = 0;
        base = ecount;
        for (int i = 0; i < 45; i++) begin
            @(negedge sys_clk);
            rel = ecount - base;
            n_chk++;
            if ({swap_buffer, busy, timeout_err, overrun, swap_count} !== exp_vec()) begin
                n_fail++;
                $display("FAIL timeout_model @%0d: got %h want %h", ecount,
                         {swap_buffer, busy, timeout_err, overrun, swap_count}, exp_vec());
            end
            n_chk++;
            if (timeout_err !== (rel >= 19) || swap_buffer !== (rel % 10 == 0)) begin
                n_fail++;
                $display("FAIL timeout_seq cycle %0d: terr %b pulse %b want %b %b",
                         rel, timeout_err, swap_buffer, rel >= 19, rel % 10 == 0);
            end
            if (rel == 19) begin
                n_chk++;
                if (busy !== 1'b0 || swap_count !== 16'd0) begin
                    n_fail++;
                    $display("FAIL timeout_idle: busy %b count %0d want 0 0",
                             busy, swap_count);
                end
            end
        end
        mode_auto = 0;
    endtask

    task automatic test_coalesce();
        int base, j, np;
        reset = 1;
        @(negedge sys_clk);
        reset = 0;
        mode_auto = 0;
        key_n = 0;
        repeat (8) @(negedge sys_clk);
        key_n = 1;
        mode_auto = 1;
        base = ecount;
        np = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge sys_clk);
            j = ecount - base;
            n_chk++;
            if ({swap_buffer, busy, timeout_err, overrun, swap_count} !== exp_vec()) begin
                n_fail++;
                $display("FAIL coalesce_model @%0d: got %h want %h", ecount,
                         {swap_buffer, busy, timeout_err, overrun, swap_count}, exp_vec());
            end
            n_chk++;
            if (swap_buffer !== (j == 7 || j == 17) || overrun !== (j >= 15)) begin
                n_fail++;
                $display("FAIL coalesce_seq cycle %0d: pulse %b ovr %b want %b %b",
                         j, swap_buffer, overrun, j == 7 || j == 17, j >= 15);
            end
            if (swap_buffer) np++;
            key_n = !(j >= 4 && j <= 7);
            mode_auto = (j <= 9);
            swap_done = (j == 15 || j == 18);
        end
        swap_done = 0;
        n_chk++;
        if (np != 2 || swap_count !== 16'd2 || overrun !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL coalesce_end: pulses %0d count %0d ovr %b busy %b want 2 2 1 0",
                     np, swap_count, overrun, busy);
        end
    endtask

    task automatic test_reset_mid();
        int base, j;
        reset = 1;
        @(negedge sys_clk);
        reset = 0;
        mode_auto = 0;
        key_n = 0;
        repeat (8) @(negedge sys_clk);
        key_n = 1;
        mode_auto = 1;
        base = ecount;
        for (int i = 0; i < 30; i++) begin
            @(negedge sys_clk);
            j = ecount - base;
            n_chk++;
            if ({swap_buffer, busy, timeout_err, overrun, swap_count} !== exp_vec()) begin
                n_fail++;
                $display("FAIL rstmid_model @%0d: got %h want %h", ecount,
                         {swap_buffer, busy, timeout_err, overrun, swap_count}, exp_vec());
            end
            n_chk++;
            if (swap_buffer !== (j == 7)) begin
                n_fail++;
                $display("FAIL rstmid_pulse cycle %0d: got %b want %b",
                         j, swap_buffer, j == 7);
            end
            key_n = !(j >= 4 && j <= 7);
            mode_auto = (j <= 9);
            swap_done = (j == 20);
            if (j == 11) begin
                n_chk++;
                if (dut.pending_q !== 1'b1 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rstmid_pre: pending %b busy %b want 1 1",
                             dut.pending_q, busy);
                end
                reset = 1;
            end
            if (j == 12) begin
                n_chk++;
                if ({swap_buffer, busy, timeout_err, overrun, swap_count} !== 20'h0 ||
                    dut.pending_q !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rstmid_vals: got %h pend %b want 0 0",
                             {swap_buffer, busy, timeout_err, overrun, swap_count},
                             dut.pending_q);
                end
                reset = 0;
            end
        end
        swap_done = 0;
        n_chk++;
        if (swap_count !== 16'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_end: count %0d busy %b want 0 0", swap_count, busy);
        end
    endtask

    task automatic test_random();
        int khold = 0;
        reset = 1;
        @(negedge sys_clk);
        reset = 0;
        for (int i = 0; i < 3000; i++) begin
            if (khold == 0) begin
                key_n = ~key_n;
                khold = $urandom_range(1, 9);
            end else khold--;
            enable = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 99) == 0) mode_auto = ~mode_auto;
            swap_done = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 599) == 0);
            @(negedge sys_clk);
            n_chk++;
            if ({swap_buffer, busy, timeout_err, overrun, swap_count} !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_model @%0d: got %h want %h", ecount,
                         {swap_buffer, busy, timeout_err, overrun, swap_count}, exp_vec());
            end
        end
        reset = 0;
        swap_done = 0;
        enable = 1;
        mode_auto = 0;
    endtask

    initial begin
        test_reset();
        test_manual();
        test_bounce();
        test_auto();
        test_timeout();
        test_coalesce();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
